pipe3_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 3-stage, 8-bit register pipeline between NREQ requesters.
- Arbitrates each cycle and issues the winner's data plus a requester ID tag into stage 1.
- Tracks per-stage valid bits and exposes a valid/ready output at stage 3.
- Applies global stall on backpressure and supports synchronous flush.
- Sits between the requesting blocks and the downstream consumer of the pipelined data.

---
 rtl/pipe3_rr_scheduler_if.sv | 37 +++
 rtl/pipe3_rr_scheduler.sv | 92 +++++++++
 tb/tb_pipe3_rr_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe3_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe3_rr_scheduler_if
// Function : Requester-side and consumer-side signals of the round-robin
//            scheduler, grouped with directional modports.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe3_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic [2:0]         stage_valid;
  logic [1:0]         occupancy;
  logic               busy;

  // Scheduler side
  modport slave (
    input  req, req_data, flush, out_ready,
    output gnt, out_valid, out_data, out_id, stage_valid, occupancy, busy
  );

  // Requesters / consumer side
  modport master (
    output req, req_data, flush, out_ready,
    input  gnt, out_valid, out_data, out_id, stage_valid, occupancy, busy
  );
endinterface
`default_nettype wire

// File: rtl/pipe3_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipe3_rr_scheduler
// Function : Round-robin arbiter feeding a shared 3-stage data/ID pipeline
//            with global stall on backpressure and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe3_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  wire                 clk,
  input  wire                 rst,   // asynchronous, active-low
  pipe3_rr_scheduler_if.slave bus
);

  logic [2:0]     r_valid;
  logic [DW-1:0]  r_data [3];
  logic [IDW-1:0] r_id   [3];
  logic [IDW-1:0] r_ptr;

  logic           w_adv;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic           w_issue;
  logic [DW-1:0]  w_sel_data;

  // The whole pipe moves only when stage 3 is empty or being consumed.
  assign w_adv = !(r_valid[2] && !bus.out_ready);

  // Round-robin search: start one past the last winner, ascending with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Grant is suppressed during reset, stall and flush so nothing is lost.
  assign w_issue    = rst && w_adv && !bus.flush && w_found;
  assign w_sel_data = bus.req_data[w_win*DW +: DW];
  assign bus.gnt    = w_issue ? (NREQ'(1) << w_win) : '0;

  // Pipeline stages: flush clears valids only, advance shifts everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int s = 0; s < 3; s++) begin
        r_data[s] <= '0;
        r_id[s]   <= '0;
      end
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid   <= {r_valid[1:0], w_issue};
      r_data[2] <= r_data[1];
      r_data[1] <= r_data[0];
      r_id[2]   <= r_id[1];
      r_id[1]   <= r_id[0];
      if (w_issue) begin
        r_data[0] <= w_sel_data;
        r_id[0]   <= w_win;
      end
    end
  end

  // Pointer remembers the last winner; reset value gives requester 0 priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (w_issue) begin
      r_ptr <= w_win;
    end
  end

  assign bus.out_valid   = r_valid[2];
  assign bus.out_data    = r_data[2];
  assign bus.out_id      = r_id[2];
  assign bus.stage_valid = r_valid;
  assign bus.occupancy   = {1'b0, r_valid[0]} + {1'b0, r_valid[1]} + {1'b0, r_valid[2]};
  assign bus.busy        = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipe3_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe3_rr_scheduler
// Function : Directed self-checking bench for pipe3_rr_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe3_rr_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] c_dat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  pipe3_rr_scheduler_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) u_if ();

  pipe3_rr_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst              = 1'b0;
    u_if.req         = '0;
    u_if.req_data    = '0;
    u_if.flush       = 1'b0;
    u_if.out_ready   = 1'b1;

    // ---- Reset state ------------------------------------------------------
    #2;
    u_if.req = 4'b0001;
    #1;
    check("rst_gnt",   32'(u_if.gnt), 32'h0);
    check("rst_sv",    32'(u_if.stage_valid), 32'h0);
    check("rst_oval",  32'(u_if.out_valid), 32'h0);
    check("rst_occ",   32'(u_if.occupancy), 32'h0);
    check("rst_busy",  32'(u_if.busy), 32'h0);
    tick();
    tick();

    // ---- Single entry latency ----------------------------------------------
    u_if.req_data = 32'h0000_00A5;
    rst = 1'b1;
    #1;
    check("t1_gnt", 32'(u_if.gnt), 32'h1);
    tick();
    u_if.req = '0;
    check("t1_sv_e0",  32'(u_if.stage_valid), 32'h1);
    check("t1_occ_e0", 32'(u_if.occupancy), 32'h1);
    tick();
    check("t1_sv_e1",  32'(u_if.stage_valid), 32'h2);
    check("t1_occ_e1", 32'(u_if.occupancy), 32'h1);
    tick();
    check("t1_oval",   32'(u_if.out_valid), 32'h1);
    check("t1_odata",  32'(u_if.out_data), 32'hA5);
    check("t1_oid",    32'(u_if.out_id), 32'h0);
    check("t1_occ_e2", 32'(u_if.occupancy), 32'h1);
    tick();
    check("t1_oval_e3", 32'(u_if.out_valid), 32'h0);
    check("t1_occ_e3",  32'(u_if.occupancy), 32'h0);

    // ---- Fairness with all requesters active -------------------------------
    do_reset();
    u_if.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    u_if.req      = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("t2_gnt%0d", c), 32'(u_if.gnt), 32'(1 << (c % 4)));
      tick();
      if (c >= 2) begin
        check($sformatf("t2_oval%0d", c), 32'(u_if.out_valid), 32'h1);
        check($sformatf("t2_oid%0d", c),  32'(u_if.out_id), 32'((c - 2) % 4));
        check($sformatf("t2_odat%0d", c), 32'(u_if.out_data), 32'(c_dat[(c - 2) % 4]));
      end
    end

    // ---- Stall with full pipeline ------------------------------------------
    u_if.out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      check($sformatf("t3_gnt%0d", s), 32'(u_if.gnt), 32'h0);
      tick();
      check($sformatf("t3_sv%0d", s),   32'(u_if.stage_valid), 32'h7);
      check($sformatf("t3_occ%0d", s),  32'(u_if.occupancy), 32'h3);
      check($sformatf("t3_oid%0d", s),  32'(u_if.out_id), 32'h1);
      check($sformatf("t3_odat%0d", s), 32'(u_if.out_data), 32'h21);
    end
    u_if.out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      check($sformatf("t3r_gnt%0d", r), 32'(u_if.gnt), 32'(1 << r));
      tick();
      check($sformatf("t3r_oval%0d", r), 32'(u_if.out_valid), 32'h1);
      check($sformatf("t3r_oid%0d", r),  32'(u_if.out_id), 32'((r + 2) % 4));
      check($sformatf("t3r_odat%0d", r), 32'(u_if.out_data), 32'(c_dat[(r + 2) % 4]));
    end

    // ---- Flush with full pipeline ------------------------------------------
    u_if.req   = 4'b0010;
    u_if.flush = 1'b1;
    #1;
    check("t4_gnt_flush", 32'(u_if.gnt), 32'h0);
    tick();
    u_if.flush = 1'b0;
    check("t4_sv",   32'(u_if.stage_valid), 32'h0);
    check("t4_busy", 32'(u_if.busy), 32'h0);
    check("t4_occ",  32'(u_if.occupancy), 32'h0);
    check("t4_oval", 32'(u_if.out_valid), 32'h0);
    #1;
    check("t4_gnt_r1", 32'(u_if.gnt), 32'h2);
    u_if.req = 4'b1111;
    #1;
    check("t4_ptr_hold", 32'(u_if.gnt), 32'h8);
    u_if.req = 4'b0010;
    #1;
    tick();
    check("t4_sv_after", 32'(u_if.stage_valid), 32'h1);

    // ---- Asynchronous reset mid-stream -------------------------------------
    u_if.req = 4'b0100;
    #1;
    check("t5_gnt2", 32'(u_if.gnt), 32'h4);
    tick();
    u_if.req = '0;
    check("t5_occ2", 32'(u_if.occupancy), 32'h2);
    check("t5_sv",   32'(u_if.stage_valid), 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_sv",   32'(u_if.stage_valid), 32'h0);
    check("t5_rst_oval", 32'(u_if.out_valid), 32'h0);
    check("t5_rst_occ",  32'(u_if.occupancy), 32'h0);
    check("t5_rst_odat", 32'(u_if.out_data), 32'h0);
    tick();
    rst = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      check($sformatf("t5_noxfer%0d", w), 32'(u_if.out_valid), 32'h0);
    end
    u_if.req = 4'b1001;
    #1;
    check("t5_gnt_first", 32'(u_if.gnt), 32'h1);
    tick();

    // ---- Wrap-around and no starvation -------------------------------------
    u_if.req = 4'b1000;
    #1;
    check("t6_gnt3", 32'(u_if.gnt), 32'h8);
    tick();
    u_if.req = 4'b1001;
    #1;
    check("t6_gnt_wrap0", 32'(u_if.gnt), 32'h1);
    tick();
    #1;
    check("t6_gnt3_again", 32'(u_if.gnt), 32'h8);
    tick();
    u_if.req = '0;
    check("t6_oid3",  32'(u_if.out_id), 32'h3);
    check("t6_odat3", 32'(u_if.out_data), 32'h43);
    tick();
    check("t6_oid0",  32'(u_if.out_id), 32'h0);
    check("t6_odat0", 32'(u_if.out_data), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no end-of-test expected end-of-test");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
